dvsd_mac_accum: RTL and testbench
=================================

// Module: dvsd_mac_accum
// PURPOSE
//  Sequential accumulation stage directly downstream of the 8x8 Dadda multiplier.
//  - Consumes the 16-bit product over a valid/ready handshake and sums a packet of products
//    into an ACC_W-bit accumulator.
//  - Presents the finished sum, term count and overflow flag on an output valid/ready handshake.
//  - Packet ends on prod_last or on reaching MAX_TERMS; turns the combinational multiplier into a dot-product/MAC path.
// PARAMETERS
//  ACC_W      24   accumulator width; legal range 16..32
//  MAX_TERMS  256  forced packet end after this many accepted products; minimum 1
//  CNT_W      $clog2(MAX_TERMS+1)  term counter width (derived, not overridden)
// PORTS
//  clock      in   1      single clock, rising edge
//  reset      in   1      synchronous, active-high
//  prod       in   16     product {m15..m0} from multiplier
//  prod_valid in   1      prod is valid this cycle
//  prod_last  in   1      final product of packet; qualified by prod_valid
//  prod_ready out  1      stage accepts a product this cycle
//  acc_data   out  ACC_W  accumulated sum
//  acc_count  out  CNT_W  number of products summed
//  acc_ovf    out  1      sum exceeded 2^ACC_W-1 during packet
//  acc_valid  out  1      acc_* outputs valid
//  acc_ready  in   1      consumer accepts result
// BEHAVIOUR
//  - Beat accepted when prod_valid & prod_ready; result transferred when acc_valid & acc_ready.
//  - Reset: state IDLE; acc_data=0, acc_count=0, acc_ovf=0, acc_valid=0.
//    prod_ready=0 in any cycle where reset is high.
//  - FSM states IDLE, ACCUM, HOLD; prod_ready = (state!=HOLD) & ~reset, registered state decode.
//  - IDLE, beat accepted: acc<=prod (zero-extended), count<=1, ovf<=0.
//    Next state HOLD if prod_last or MAX_TERMS==1, else ACCUM.
//  - ACCUM, beat accepted: acc<=acc+prod, count<=count+1.
//    Next state HOLD if prod_last or count+1==MAX_TERMS, else stay in ACCUM.
//    No beat accepted: hold all state, no timeout.
//  - HOLD: acc_valid=1; acc_data/count/ovf stable until transfer; on transfer go to IDLE, acc_valid=0 next cycle.
//  - Latency: acc_valid asserts the cycle after the closing beat is accepted.
//    Min packet period = N beats + 1 HOLD cycle (one bubble per packet).
//  - Arithmetic: unsigned, (ACC_W+1)-bit internal sum; carry-out sets sticky ovf for rest of packet.
//  - Zero-valued products count as terms; prod_last ignored unless prod_valid.
//  - Reset mid-packet discards partial sum; no acc_valid is produced for it.
//  - acc_ready while in IDLE/ACCUM: no effect.
// CONFIGURATION
//  DVSD_MAC_SAT_EN defined: on carry-out, acc clamps to {ACC_W{1'b1}} and stays clamped for the rest of the packet; ovf=1.
//  Not defined: sum wraps modulo 2^ACC_W; ovf=1; later terms keep adding to the wrapped value.
// STRUCTURE
//  - Shared header dvsd_mac_defs.vh holds:
//    - state encodings IDLE=2'd0, ACCUM=2'd1, HOLD=2'd2
//    - PROD_W=16
//    - default ACC_W and MAX_TERMS
//  - One sub-module, dvsd_acc_add: ACC_W adder plus 16-bit addend, with carry-out and macro-controlled saturation. Purely combinational.
//  - FSM, counter and output registers live in dvsd_mac_accum.
// TESTING
//  - 3 beats of prod=65025 (255*255), last on the 3rd:
//    acc_data=195075 (0x2FA03), acc_count=3, acc_ovf=0, acc_valid the cycle after the 3rd beat.
//  - Backpressure: hold acc_ready=0 for 5 cycles in HOLD:
//    acc_valid stays 1, acc_* stable, prod_ready=0; transfer on the 6th cycle, IDLE next.
//  - MAX_TERMS=4, four beats prod=1000, prod_last=0: auto-close with acc_data=4000, acc_count=4.
//  - ACC_W=16, two beats prod=65025:
//    without macro acc_data=64514 (0xFC02), acc_ovf=1; with DVSD_MAC_SAT_EN acc_data=0xFFFF, acc_ovf=1.
//  - Reset asserted for 1 cycle after 2 accepted beats:
//    no acc_valid; next packet {7, last} yields acc_data=7, acc_count=1.
//  - Single beat prod=0, prod_last=1: acc_data=0, acc_count=1, acc_ovf=0.

Source files
------------

// File: rtl/dvsd_mac_accum_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dvsd_mac_accum_pkg
// Description : Shared definitions for the MAC accumulation stage.
//               Holds the FSM state encoding, the product width and the
//               default ACC_W / MAX_TERMS values used by the stage and its
//               adder.
// Revision    : 1.0 - initial release
// ============================================================================
package dvsd_mac_accum_pkg;

   localparam int PROD_W        = 16;
   localparam int DEF_ACC_W     = 24;
   localparam int DEF_MAX_TERMS = 256;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      HOLD  = 2'd2
   } state_t;

endpackage
`default_nettype wire

// File: rtl/dvsd_acc_add.sv
`default_nettype none
// ============================================================================
// Module      : dvsd_acc_add
// Description : Purely combinational ACC_W-bit accumulator adder with a
//               16-bit zero-extended addend and carry-out.
//               Macro DVSD_MAC_SAT_EN: when defined, a carry-out clamps the
//               sum to all ones; otherwise the sum wraps modulo 2^ACC_W.
// Ports       : acc    in  ACC_W  current accumulator value
//               addend in  16     product to add
//               sum    out ACC_W  new accumulator value
//               carry  out 1      carry-out of the (ACC_W+1)-bit sum
// Revision    : 1.0 - initial release
// ============================================================================
module dvsd_acc_add
   import dvsd_mac_accum_pkg::*;
#(
   parameter int ACC_W = DEF_ACC_W
) (
   input  logic [ACC_W-1:0]  acc,
   input  logic [PROD_W-1:0] addend,
   output logic [ACC_W-1:0]  sum,
   output logic              carry
);

   logic [ACC_W:0] w_sum_ext;

   assign w_sum_ext = {1'b0, acc} + {{(ACC_W + 1 - PROD_W){1'b0}}, addend};
   assign carry     = w_sum_ext[ACC_W];

`ifdef DVSD_MAC_SAT_EN
   // Once clamped, any further non-zero addend carries again and re-clamps,
   // so the saturated value persists for the rest of the packet.
   assign sum = carry ? {ACC_W{1'b1}} : w_sum_ext[ACC_W-1:0];
`else
   assign sum = w_sum_ext[ACC_W-1:0];
`endif

endmodule
`default_nettype wire

// File: rtl/dvsd_mac_accum.sv
`default_nettype none
// ============================================================================
// Module      : dvsd_mac_accum
// Description : Sequential accumulation stage behind the 8x8 multiplier.
//               Sums a packet of 16-bit products (ended by prod_last or by
//               reaching MAX_TERMS) and presents sum, term count and
//               overflow flag on an output valid/ready handshake.
//               Macro DVSD_MAC_SAT_EN selects saturating instead of
//               wrapping accumulation (see dvsd_acc_add).
// Ports       : clock      in  1      rising-edge clock
//               reset      in  1      synchronous active-high reset
//               prod       in  16     product from multiplier
//               prod_valid in  1      prod valid
//               prod_last  in  1      last product of packet
//               prod_ready out 1      stage accepts a product
//               acc_data   out ACC_W  accumulated sum
//               acc_count  out CNT_W  number of products summed
//               acc_ovf    out 1      sum exceeded 2^ACC_W-1
//               acc_valid  out 1      acc_* valid
//               acc_ready  in  1      consumer accepts result
// Revision    : 1.0 - initial release
// ============================================================================
module dvsd_mac_accum
   import dvsd_mac_accum_pkg::*;
#(
   parameter  int ACC_W     = DEF_ACC_W,
   parameter  int MAX_TERMS = DEF_MAX_TERMS,
   localparam int CNT_W     = $clog2(MAX_TERMS + 1)
) (
   input  logic              clock,
   input  logic              reset,
   input  logic [PROD_W-1:0] prod,
   input  logic              prod_valid,
   input  logic              prod_last,
   output logic              prod_ready,
   output logic [ACC_W-1:0]  acc_data,
   output logic [CNT_W-1:0]  acc_count,
   output logic              acc_ovf,
   output logic              acc_valid,
   input  logic              acc_ready
);

   localparam logic [CNT_W-1:0] C_MAX_TERMS = CNT_W'(MAX_TERMS);
   localparam logic [CNT_W-1:0] C_ONE       = CNT_W'(1);

   state_t             r_state;
   state_t             w_next_state;
   logic [ACC_W-1:0]   r_acc;
   logic [CNT_W-1:0]   r_count;
   logic               r_ovf;
   logic [ACC_W-1:0]   w_sum;
   logic               w_carry;
   logic [CNT_W-1:0]   w_count_inc;
   logic               w_accept;
   logic               w_close;

   dvsd_acc_add #(
      .ACC_W (ACC_W)
   ) u_add (
      .acc    (r_acc),
      .addend (prod),
      .sum    (w_sum),
      .carry  (w_carry)
   );

   assign w_count_inc = r_count + C_ONE;

   // FSM state register
   always_ff @(posedge clock) begin
      if (reset) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // FSM next state and handshake decode; ready/valid come only from the
   // registered state (and reset), never from the input handshake.
   always_comb begin
      w_next_state = r_state;
      prod_ready   = 1'b0;
      acc_valid    = 1'b0;
      w_accept     = 1'b0;
      w_close      = 1'b0;
      case (r_state)
         IDLE: begin
            prod_ready = ~reset;
            w_accept   = prod_valid & ~reset;
            w_close    = prod_last | (MAX_TERMS == 1);
            if (w_accept) begin
               w_next_state = w_close ? HOLD : ACCUM;
            end
         end
         ACCUM: begin
            prod_ready = ~reset;
            w_accept   = prod_valid & ~reset;
            w_close    = prod_last | (w_count_inc == C_MAX_TERMS);
            if (w_accept && w_close) begin
               w_next_state = HOLD;
            end
         end
         HOLD: begin
            acc_valid = 1'b1;
            if (acc_ready) begin
               w_next_state = IDLE;
            end
         end
         default: begin
            w_next_state = IDLE;
         end
      endcase
   end

   // Accumulator, term counter and sticky overflow. The first beat of a
   // packet loads rather than adds, so no clear cycle is needed between
   // packets.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_acc   <= '0;
         r_count <= '0;
         r_ovf   <= 1'b0;
      end else if (w_accept) begin
         if (r_state == IDLE) begin
            r_acc   <= ACC_W'(prod);
            r_count <= C_ONE;
            r_ovf   <= 1'b0;
         end else begin
            r_acc   <= w_sum;
            r_count <= w_count_inc;
            r_ovf   <= r_ovf | w_carry;
         end
      end
   end

   assign acc_data  = r_acc;
   assign acc_count = r_count;
   assign acc_ovf   = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_dvsd_mac_accum.sv
`default_nettype none
// ============================================================================
// Module      : tb_dvsd_mac_accum
// Description : Self-checking bench for dvsd_mac_accum. Two instances:
//               A = defaults (ACC_W=24, MAX_TERMS=256),
//               B = ACC_W=16, MAX_TERMS=4. The variable sel chooses which
//               instance receives beats and is observed. Expected results
//               come from a packet-level arithmetic model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dvsd_mac_accum;

   logic        clock = 1'b0;
   logic        reset;
   logic [15:0] prod;
   logic        prod_valid;
   logic        prod_last;
   logic        acc_ready;
   bit          sel;

   logic        v_a, rdy_a, val_a, ovf_a;
   logic [23:0] data_a;
   logic [8:0]  cnt_a;
   logic        v_b, rdy_b, val_b, ovf_b;
   logic [15:0] data_b;
   logic [2:0]  cnt_b;

   logic        obs_ready, obs_valid, obs_ovf;
   logic [31:0] obs_data;
   logic [8:0]  obs_count;

   int checks = 0;
   int errors = 0;

   always #5 clock = ~clock;

   assign v_a = prod_valid & ~sel;
   assign v_b = prod_valid & sel;

   dvsd_mac_accum u_dut_a (
      .clock      (clock),
      .reset      (reset),
      .prod       (prod),
      .prod_valid (v_a),
      .prod_last  (prod_last),
      .prod_ready (rdy_a),
      .acc_data   (data_a),
      .acc_count  (cnt_a),
      .acc_ovf    (ovf_a),
      .acc_valid  (val_a),
      .acc_ready  (acc_ready)
   );

   dvsd_mac_accum #(
      .ACC_W     (16),
      .MAX_TERMS (4)
   ) u_dut_b (
      .clock      (clock),
      .reset      (reset),
      .prod       (prod),
      .prod_valid (v_b),
      .prod_last  (prod_last),
      .prod_ready (rdy_b),
      .acc_data   (data_b),
      .acc_count  (cnt_b),
      .acc_ovf    (ovf_b),
      .acc_valid  (val_b),
      .acc_ready  (acc_ready)
   );

   always_comb begin
      if (sel) begin
         obs_ready = rdy_b;
         obs_valid = val_b;
         obs_ovf   = ovf_b;
         obs_data  = {16'd0, data_b};
         obs_count = {6'd0, cnt_b};
      end else begin
         obs_ready = rdy_a;
         obs_valid = val_a;
         obs_ovf   = ovf_a;
         obs_data  = {8'd0, data_a};
         obs_count = cnt_a;
      end
   end

   // Packet-level model: the packet's true total, bounded by the width.
   function automatic void model(input bit s, input longint total,
                                 output logic [31:0] d, output logic o);
      longint lim;
      lim = s ? 64'd65536 : 64'd16777216;
      o   = (total >= lim);
`ifdef DVSD_MAC_SAT_EN
      d = o ? 32'(lim - 1) : 32'(total);
`else
      d = 32'(total % lim);
`endif
   endfunction

   function automatic logic [15:0] rand_prod();
      case ($urandom_range(0, 3))
         0:       return 16'd0;
         1:       return 16'hFFFF;
         2:       return 16'd65025;
         default: return 16'($urandom);
      endcase
   endfunction

   task automatic drive_beat(input logic [15:0] p, input bit last);
      int waits;
      waits      = 0;
      prod       = p;
      prod_last  = last;
      prod_valid = 1'b1;
      acc_ready  = 1'($urandom);
      while (obs_ready !== 1'b1 && waits < 20) begin
         @(negedge clock);
         waits++;
      end
      if (waits >= 20) begin
         checks++;
         errors++;
         $display("FAIL beat_timeout: prod_ready=%b, required 1", obs_ready);
      end
      @(negedge clock);
      prod_valid = 1'b0;
      prod_last  = 1'($urandom);
      prod       = 16'($urandom);
      acc_ready  = 1'b0;
   endtask

   task automatic expect_result(input logic [31:0] ed, input logic [8:0] ec,
                                input logic eo, input int stall, input string tag);
      acc_ready = 1'b0;
      for (int i = 0; i <= stall; i++) begin
         if (i == stall) acc_ready = 1'b1;
         checks++;
         if ({obs_valid, obs_ready, obs_data, obs_count, obs_ovf} !== {1'b1, 1'b0, ed, ec, eo}) begin
            errors++;
            $display("FAIL %s hold%0d: got valid=%b ready=%b data=%0d count=%0d ovf=%b, required valid=1 ready=0 data=%0d count=%0d ovf=%b",
                     tag, i, obs_valid, obs_ready, obs_data, obs_count, obs_ovf, ed, ec, eo);
         end
         @(negedge clock);
      end
      acc_ready = 1'b0;
      checks++;
      if ({obs_valid, obs_ready} !== 2'b01) begin
         errors++;
         $display("FAIL %s after_transfer: got valid=%b ready=%b, required valid=0 ready=1",
                  tag, obs_valid, obs_ready);
      end
   endtask

   task automatic run_packet(input bit s, input logic [15:0] vals[$], input bit close_last,
                             input int stall, input string tag);
      longint      total;
      int          n;
      int          maxt;
      bit          last;
      logic [31:0] ed;
      logic        eo;
      sel   = s;
      maxt  = s ? 4 : 256;
      total = 0;
      n     = 0;
      for (int i = 0; i < vals.size(); i++) begin
         last = close_last && (i == vals.size() - 1);
         drive_beat(vals[i], last);
         n++;
         total += longint'(vals[i]);
         if (last || n == maxt) begin
            model(s, total, ed, eo);
            expect_result(ed, 9'(n), eo, stall, tag);
            n     = 0;
            total = 0;
         end else begin
            checks++;
            if (obs_valid !== 1'b0) begin
               errors++;
               $display("FAIL %s open_beat%0d: acc_valid=%b, required 0", tag, i, obs_valid);
            end
         end
      end
   endtask

   task automatic do_reset(input int cycles);
      @(negedge clock);
      reset      = 1'b1;
      prod_valid = 1'b0;
      #1;
      checks++;
      if (obs_ready !== 1'b0) begin
         errors++;
         $display("FAIL reset_ready: prod_ready=%b, required 0", obs_ready);
      end
      repeat (cycles) @(negedge clock);
      checks++;
      if ({obs_valid, obs_ready, obs_data, obs_count, obs_ovf} !== '0) begin
         errors++;
         $display("FAIL reset_state: valid=%b ready=%b data=%0d count=%0d ovf=%b, required all 0",
                  obs_valid, obs_ready, obs_data, obs_count, obs_ovf);
      end
      reset = 1'b0;
      #1;
   endtask

   task automatic test_reset();
      sel = 1'b0;
      do_reset(2);
      checks++;
      if (obs_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_release_ready: prod_ready=%b, required 1", obs_ready);
      end
      sel = 1'b1;
      #1;
      checks++;
      if ({obs_valid, obs_ready, obs_data, obs_count, obs_ovf} !== {1'b0, 1'b1, 32'd0, 9'd0, 1'b0}) begin
         errors++;
         $display("FAIL reset_state_b: valid=%b ready=%b data=%0d count=%0d ovf=%b, required ready=1 others 0",
                  obs_valid, obs_ready, obs_data, obs_count, obs_ovf);
      end
      sel = 1'b0;
   endtask

   task automatic test_basic();
      logic [15:0] q[$];
      q = {16'd65025, 16'd65025, 16'd65025};
      run_packet(1'b0, q, 1'b1, 0, "basic_3x65025");
   endtask

   task automatic test_backpressure();
      logic [15:0] q[$];
      q = {16'd65025, 16'd65025, 16'd65025};
      run_packet(1'b0, q, 1'b1, 5, "backpressure");
   endtask

   task automatic test_max_terms();
      logic [15:0] q[$];
      q = {16'd1000, 16'd1000, 16'd1000, 16'd1000};
      run_packet(1'b1, q, 1'b0, 0, "max_terms_4");
      q = {};
      repeat (256) q.push_back(16'hFFFF);
      run_packet(1'b0, q, 1'b0, 1, "max_terms_256");
   endtask

   task automatic test_overflow();
      logic [15:0] q[$];
      q = {16'd65025, 16'd65025};
      run_packet(1'b1, q, 1'b1, 0, "overflow_16");
      q = {16'hFFFF, 16'd2, 16'd0, 16'd5};
      run_packet(1'b1, q, 1'b0, 0, "overflow_sticky");
   endtask

   task automatic test_reset_mid();
      logic [15:0] q[$];
      sel = 1'b0;
      drive_beat(16'd123, 1'b0);
      drive_beat(16'd456, 1'b0);
      do_reset(1);
      repeat (2) @(negedge clock);
      checks++;
      if (obs_valid !== 1'b0) begin
         errors++;
         $display("FAIL reset_mid_novalid: acc_valid=%b, required 0", obs_valid);
      end
      q = {16'd7};
      run_packet(1'b0, q, 1'b1, 0, "after_reset_7");
   endtask

   task automatic test_zero();
      logic [15:0] q[$];
      q = {16'd0};
      run_packet(1'b0, q, 1'b1, 0, "single_zero");
   endtask

   task automatic test_back_to_back();
      logic [15:0] q[$];
      for (int k = 0; k < 30; k++) begin
         q = {};
         repeat ($urandom_range(1, 6)) q.push_back(rand_prod());
         run_packet(1'($urandom), q, 1'b1, $urandom_range(0, 3), "random_pkt");
      end
   endtask

   initial begin
      reset      = 1'b1;
      prod       = '0;
      prod_valid = 1'b0;
      prod_last  = 1'b0;
      acc_ready  = 1'b0;
      sel        = 1'b0;
      test_reset();
      test_basic();
      test_backpressure();
      test_max_terms();
      test_overflow();
      test_reset_mid();
      test_zero();
      test_back_to_back();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete, errors so far %0d", errors);
      $fatal(1);
   end

endmodule
`default_nettype wire
